// File: rtl/hilo_ctrl.sv
// hilo_ctrl: HI/LO register file with a multi-cycle multiply/divide sequencer.
//
// Ports
//   clk      sole clock, rising edge
//   reset    asynchronous, active-low reset
//   start    single-cycle qualifier for op/A/B from the EX stage
//   op       1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 0/7 no-op
//   A, B     operands (A is multiplicand/dividend and the mthi/mtlo source)
//   rd_sel   mfhi/mflo read select: 0 HI, 1 LO
//   Busy     a multiply or divide is in flight
//   Stall    hazard request: Busy, or a new mult/div being presented
//   HI, LO   architectural HI/LO values
//   rd_data  combinational HI/LO read data
module hilo_ctrl #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        rd_sel,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] rd_data
);

  localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = (MAX_CYCLES < 1) ? 1 : $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    op_q, op_n;
  logic [31:0]   a_q, a_n;
  logic [31:0]   b_q, b_n;
  logic [31:0]   hi_q, hi_n;
  logic [31:0]   lo_q, lo_n;
  res_t          res_now, res_busy;

  // Result of a mult/div on the given operands. wr=0 means HI/LO must be
  // left alone (divide by zero, or not an arithmetic op).
  function automatic res_t compute(input logic [2:0] f_op, input logic [31:0] a,
                                   input logic [31:0] b);
    res_t               r;
    logic [63:0]        prod;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    r    = '0;
    prod = '0;
    sa   = a;
    sb   = b;
    case (f_op)
      OP_MULT: begin
        prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        r.wr = 1'b1;
        r.hi = prod[63:32];
        r.lo = prod[31:0];
      end
      OP_MULTU: begin
        prod = {32'd0, a} * {32'd0, b};
        r.wr = 1'b1;
        r.hi = prod[63:32];
        r.lo = prod[31:0];
      end
      OP_DIV: begin
        if (b != '0) begin
          r.wr = 1'b1;
          // Most-negative / -1 overflows; pin the result rather than rely
          // on what the divider produces.
          if (a == 32'h8000_0000 && b == '1) begin
            r.lo = 32'h8000_0000;
            r.hi = '0;
          end else begin
            r.lo = sa / sb;
            r.hi = sa % sb;
          end
        end
      end
      OP_DIVU: begin
        if (b != '0) begin
          r.wr = 1'b1;
          r.lo = a / b;
          r.hi = a % b;
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    res_now  = compute(op, A, B);
    res_busy = compute(op_q, a_q, b_q);
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op_q;
    a_n     = a_q;
    b_n     = b_q;
    hi_n    = hi_q;
    lo_n    = lo_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              if (MUL_CYCLES == 0) begin
                if (res_now.wr) begin
                  hi_n = res_now.hi;
                  lo_n = res_now.lo;
                end
              end else begin
                op_n    = op;
                a_n     = A;
                b_n     = B;
                cnt_n   = CW'(MUL_CYCLES);
                state_n = S_MUL;
              end
            end
            OP_DIV, OP_DIVU: begin
              if (DIV_CYCLES == 0) begin
                if (res_now.wr) begin
                  hi_n = res_now.hi;
                  lo_n = res_now.lo;
                end
              end else begin
                op_n    = op;
                a_n     = A;
                b_n     = B;
                cnt_n   = CW'(DIV_CYCLES);
                state_n = S_DIV;
              end
            end
            OP_MTHI: hi_n = A;
            OP_MTLO: lo_n = A;
            default: ;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        cnt_n = cnt - CW'(1);
        if (cnt <= CW'(1)) begin
          state_n = S_IDLE;
          if (res_busy.wr) begin
            hi_n = res_busy.hi;
            lo_n = res_busy.lo;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      op_q  <= op_n;
      a_q   <= a_n;
      b_q   <= b_n;
      hi_q  <= hi_n;
      lo_q  <= lo_n;
    end
  end

  assign Busy    = (state != S_IDLE);
  assign Stall   = Busy | (start & (op != 3'd0) & (op <= OP_DIVU));
  assign HI      = hi_q;
  assign LO      = lo_q;
  assign rd_data = rd_sel ? lo_q : hi_q;

endmodule
